readln: RTL

READLN -- requirements
Module: readln

---
 rtl/rpn_pkg.sv | 22 ++
 rtl/ascii_digit.sv | 18 +
 rtl/readln.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
`default_nettype none
// ============================================================================
//  rpn_pkg : ASCII constants and readln state encoding shared with println
//  Rev 1.0
// ============================================================================
package rpn_pkg;

    localparam logic [7:0] c_ASCII_ZERO  = 8'h30;
    localparam logic [7:0] c_ASCII_NINE  = 8'h39;
    localparam logic [7:0] c_ASCII_CR    = 8'h0D;
    localparam logic [7:0] c_ASCII_LF    = 8'h0A;
    localparam logic [7:0] c_ASCII_SPACE = 8'h20;
    localparam logic [7:0] c_ASCII_MINUS = 8'h2D;

    typedef enum logic [1:0] {
        RL_IDLE    = 2'd0,
        RL_ACCUM   = 2'd1,
        RL_DISCARD = 2'd2
    } rl_state_t;

endpackage : rpn_pkg
`default_nettype wire

// File: rtl/ascii_digit.sv
`default_nettype none
// ============================================================================
//  ascii_digit : combinational ASCII '0'..'9' detector and nibble extractor
//  Rev 1.0
// ============================================================================
module ascii_digit
    import rpn_pkg::*;
(
    input  logic [7:0] din,
    output logic       is_digit,
    output logic [3:0] digit
);

    assign is_digit = (din >= c_ASCII_ZERO) && (din <= c_ASCII_NINE);
    assign digit    = din[3:0];

endmodule : ascii_digit
`default_nettype wire

// File: rtl/readln.sv
`default_nettype none
// ============================================================================
//  readln : decimal ASCII line parser, TERM_CHAR-terminated, 16-bit result
//  Optional signed parsing with macro READLN_SIGN_EN.          Rev 1.0
// ============================================================================
module readln
    import rpn_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR  = 8'h0A,
    parameter int         MAX_DIGITS = 5
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic [15:0] value,
    output logic        valid,
    output logic        err,
    output logic        busy
);

    localparam int CW = $clog2(MAX_DIGITS + 2);

    rl_state_t          r_state;
    logic [19:0]        r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_seen;

    logic               w_is_digit;
    logic [3:0]         w_digit;
    logic [19:0]        w_acc_next;
    logic               w_sig;
    logic [CW-1:0]      w_cnt_next;
    logic [19:0]        w_bound;
    logic [15:0]        w_result;
    logic               w_ovf;
    logic               w_too_long;

    ascii_digit u_digit (
        .din      (din),
        .is_digit (w_is_digit),
        .digit    (w_digit)
    );

`ifdef READLN_SIGN_EN
    logic r_neg;
    assign w_bound  = r_neg ? 20'd32768 : 20'd32767;
    assign w_result = r_neg ? (~r_acc[15:0] + 16'd1) : r_acc[15:0];
`else
    assign w_bound  = 20'd65535;
    assign w_result = r_acc[15:0];
`endif

    // Leading zeros leave acc at zero, so they never advance the digit count.
    assign w_acc_next = (r_acc * 20'd10) + {16'd0, w_digit};
    assign w_sig      = (r_acc != 20'd0) || (w_digit != 4'd0);
    assign w_cnt_next = r_cnt + {{(CW-1){1'b0}}, w_sig};
    assign w_ovf      = w_acc_next > w_bound;
    assign w_too_long = w_cnt_next > CW'(MAX_DIGITS);

    assign busy = (r_state != RL_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RL_IDLE;
            r_acc   <= 20'd0;
            r_cnt   <= '0;
            r_seen  <= 1'b0;
            value   <= 16'd0;
            valid   <= 1'b0;
            err     <= 1'b0;
`ifdef READLN_SIGN_EN
            r_neg   <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (din_valid) begin
                if (din == TERM_CHAR) begin
                    // r_seen is low only after a lone sign, which is an error line
                    if (r_state == RL_ACCUM && r_seen) begin
                        value <= w_result;
                        valid <= 1'b1;
                    end else if (r_state != RL_IDLE) begin
                        err   <= 1'b1;
                    end
                    r_state <= RL_IDLE;
                    r_acc   <= 20'd0;
                    r_cnt   <= '0;
                    r_seen  <= 1'b0;
`ifdef READLN_SIGN_EN
                    r_neg   <= 1'b0;
`endif
                end else if (din == c_ASCII_CR || din == c_ASCII_SPACE) begin
                    r_state <= r_state;
                end else if (r_state != RL_DISCARD) begin
                    if (w_is_digit) begin
                        if (w_ovf || w_too_long) begin
                            r_state <= RL_DISCARD;
                        end else begin
                            r_acc   <= w_acc_next;
                            r_cnt   <= w_cnt_next;
                            r_seen  <= 1'b1;
                            r_state <= RL_ACCUM;
                        end
                    end
`ifdef READLN_SIGN_EN
                    else if (din == c_ASCII_MINUS && r_state == RL_IDLE) begin
                        r_neg   <= 1'b1;
                        r_state <= RL_ACCUM;
                    end
`endif
                    else begin
                        r_state <= RL_DISCARD;
                    end
                end
            end
        end
    end

endmodule : readln
`default_nettype wire
